// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: small in-order FIFO of ALU results that drains into the
// register-file write port, commits NZCV on retire and reports pending writes.
module alu_writeback_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_r1,
  input  logic [RD_W-1:0]            in_rd,
  input  logic                       in_wren,
  input  logic                       in_setflags,
  input  logic                       in_n,
  input  logic                       in_z,
  input  logic                       in_c,
  input  logic                       in_v,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [DATA_W-1:0]          wb_data,
  output logic [RD_W-1:0]            wb_rd,
  output logic                       wb_en,
  output logic [3:0]                 nzcv,
  output logic [(1<<RD_W)-1:0]       pending_mask,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] r1;
    logic [RD_W-1:0]   rd;
    logic              wren;
    logic              sf;
    logic [3:0]        flags;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [3:0]        nzcv_q;
  logic              push, pop;
  entry_t            head;
  logic [PW-1:0]     off;
  logic [(1<<RD_W)-1:0] pend;

  assign in_ready = (count_q != CW'(DEPTH));
  assign wb_valid = (count_q != '0);
  assign push     = in_valid && in_ready;
  assign pop      = wb_valid && wb_ready;
  assign head     = mem_q[rptr_q];

  // Outputs are forced to zero while empty so stale slots never leak out.
  assign wb_data  = wb_valid ? head.r1   : '0;
  assign wb_rd    = wb_valid ? head.rd   : '0;
  assign wb_en    = wb_valid ? head.wren : 1'b0;
  assign nzcv     = nzcv_q;
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // A slot is occupied when its distance from the read pointer is below count.
  always_comb begin
    pend = '0;
    off  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      off = PW'(j) - rptr_q;
      if ({1'b0, off} < count_q && mem_q[j].wren) pend[mem_q[j].rd] = 1'b1;
    end
  end
  assign pending_mask = pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      nzcv_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= '{r1: in_r1, rd: in_rd, wren: in_wren, sf: in_setflags,
                           flags: {in_n, in_z, in_c, in_v}};
        wptr_q <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
        if (head.sf) nzcv_q <= head.flags;
      end
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage with hand-computed expectations.
module tb_alu_writeback_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_r1;
  logic [3:0]  in_rd;
  logic        in_wren, in_setflags, in_n, in_z, in_c, in_v;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_data;
  logic [3:0]  wb_rd;
  logic        wb_en;
  logic [3:0]  nzcv;
  logic [15:0] pending_mask;
  logic [1:0]  count;

  int n_checks = 0;
  int n_fails  = 0;

  alu_writeback_stage #(.DATA_W(32), .RD_W(4), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_r1(in_r1), .in_rd(in_rd),
    .in_wren(in_wren), .in_setflags(in_setflags),
    .in_n(in_n), .in_z(in_z), .in_c(in_c), .in_v(in_v),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_en(wb_en), .nzcv(nzcv), .pending_mask(pending_mask), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] r1, input logic [3:0] rd, input logic wren,
                      input logic sf, input logic [3:0] f);
    in_valid = 1'b1; in_r1 = r1; in_rd = rd; in_wren = wren; in_setflags = sf;
    {in_n, in_z, in_c, in_v} = f;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_r1 = '0; in_rd = '0; in_wren = 1'b0; in_setflags = 1'b0;
    {in_n, in_z, in_c, in_v} = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; wb_ready = 1'b0;
    idle();
    tick();
    rst = 1'b0;
    check("rst_count",   32'(count), 0);
    check("rst_wbvalid", 32'(wb_valid), 0);
    check("rst_inready", 32'(in_ready), 1);
    check("rst_nzcv",    32'(nzcv), 0);
    check("rst_pending", 32'(pending_mask), 0);
    check("rst_wbdata",  wb_data, 0);
    check("rst_wbrd",    32'(wb_rd), 0);
    check("rst_wben",    32'(wb_en), 0);

    // single push, retire next cycle
    wb_ready = 1'b1;
    push(32'h0000_0000, 4'd3, 1'b1, 1'b1, 4'b0100);
    tick();
    idle();
    check("single_wbvalid", 32'(wb_valid), 1);
    check("single_wbrd",    32'(wb_rd), 3);
    check("single_wben",    32'(wb_en), 1);
    check("single_pending", 32'(pending_mask), 32'h0008);
    check("single_nzcv_pre", 32'(nzcv), 0);
    tick();
    check("single_nzcv",    32'(nzcv), 32'h4);
    check("single_empty",   32'(wb_valid), 0);
    check("single_pend_clr", 32'(pending_mask), 0);

    // fill and stall
    wb_ready = 1'b0;
    push(32'h11, 4'd1, 1'b1, 1'b0, 4'b0000);
    tick();
    push(32'h22, 4'd2, 1'b1, 1'b0, 4'b0000);
    tick();
    check("fill_count",   32'(count), 2);
    check("fill_inready", 32'(in_ready), 0);
    check("fill_pending", 32'(pending_mask), 32'h0006);
    push(32'h33, 4'd7, 1'b1, 1'b0, 4'b0000);
    tick();
    check("stall_count",  32'(count), 2);
    check("stall_wbdata", wb_data, 32'h11);
    check("stall_wbrd",   32'(wb_rd), 1);
    wb_ready = 1'b1;
    tick();
    check("drain1_count",   32'(count), 1);
    check("drain1_wbrd",    32'(wb_rd), 2);
    check("drain1_inready", 32'(in_ready), 1);
    check("drain1_pending", 32'(pending_mask), 32'h0004);
    tick();
    idle();
    check("drain2_count",   32'(count), 1);
    check("drain2_wbrd",    32'(wb_rd), 7);
    check("drain2_wbdata",  wb_data, 32'h33);
    check("drain2_pending", 32'(pending_mask), 32'h0080);
    tick();
    check("drain3_count", 32'(count), 0);

    // concurrent push/pop at count=1 across pointer wrap
    wb_ready = 1'b0;
    push(32'd100, 4'd8, 1'b1, 1'b0, 4'b0000);
    tick();
    wb_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      push(32'd101 + 32'(k), 4'(9 + k), 1'b1, 1'b0, 4'b0000);
      tick();
      check($sformatf("conc_count_%0d", k), 32'(count), 1);
      check($sformatf("conc_data_%0d", k), wb_data, 32'd101 + 32'(k));
    end
    idle();
    tick();
    check("conc_end_count", 32'(count), 0);
    check("conc_end_nzcv",  32'(nzcv), 32'h4);

    // flag gating
    push(32'h8000_0000, 4'd1, 1'b1, 1'b0, 4'b1000);
    tick();
    idle();
    tick();
    check("flag_nosf", 32'(nzcv), 32'h4);
    push(32'h1, 4'd2, 1'b1, 1'b1, 4'b1000);
    tick();
    idle();
    tick();
    check("flag_sf_n", 32'(nzcv), 32'h8);
    push(32'h2, 4'd4, 1'b0, 1'b1, 4'b0100);
    tick();
    idle();
    check("flag_wben0",   32'(wb_en), 0);
    check("flag_wbvalid", 32'(wb_valid), 1);
    check("flag_pend0",   32'(pending_mask), 0);
    tick();
    check("flag_sf_z", 32'(nzcv), 32'h4);

    // duplicate destination
    wb_ready = 1'b0;
    push(32'h1, 4'd5, 1'b1, 1'b0, 4'b0000);
    tick();
    push(32'h2, 4'd5, 1'b1, 1'b0, 4'b0000);
    tick();
    idle();
    check("dup_pend_both", 32'(pending_mask), 32'h0020);
    wb_ready = 1'b1;
    tick();
    check("dup_pend_one", 32'(pending_mask), 32'h0020);
    check("dup_data",     wb_data, 32'h2);
    tick();
    check("dup_pend_clr", 32'(pending_mask), 0);

    // reset mid-operation
    push(32'h9, 4'd6, 1'b1, 1'b1, 4'b1010);
    tick();
    idle();
    tick();
    check("mid_nzcv_pre", 32'(nzcv), 32'hA);
    wb_ready = 1'b0;
    push(32'hA, 4'd10, 1'b1, 1'b1, 4'b0001);
    tick();
    push(32'hB, 4'd11, 1'b1, 1'b1, 4'b0001);
    tick();
    check("mid_count_pre", 32'(count), 2);
    rst = 1'b1; wb_ready = 1'b1;
    push(32'hC, 4'd12, 1'b1, 1'b1, 4'b0001);
    tick();
    rst = 1'b0;
    idle();
    check("mid_count",   32'(count), 0);
    check("mid_wbvalid", 32'(wb_valid), 0);
    check("mid_nzcv",    32'(nzcv), 0);
    check("mid_pending", 32'(pending_mask), 0);
    check("mid_inready", 32'(in_ready), 1);
    tick();
    check("mid_after_count", 32'(count), 0);
    check("mid_after_nzcv",  32'(nzcv), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
